matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 39 +++
 rtl/matmul_sequencer_if.sv | 38 +++
 rtl/matmul_step_cnt.sv | 38 +++
 rtl/matmul_sequencer.sv | 163 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and width helpers
// for the matmul control sequencer.
`timescale 1ns/1ps
package matmul_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned BUS_WIDTH      = 32;
  localparam int unsigned DIM            = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned SP_NTARGETS    = 4;
  localparam int unsigned LOC_ADDR_WIDTH = 6;
  localparam int unsigned SP_BASE        = 16;
  localparam int unsigned PE_LAT         = 2 * DIM - 1;

  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TGT_W = clog2_min1(SP_NTARGETS);
  localparam int unsigned IDX_W = clog2_min1(DIM);

  localparam int ST_IDLE  = 0;
  localparam int ST_CLEAR = 1;
  localparam int ST_FEED  = 2;
  localparam int ST_DRAIN = 3;
  localparam int ST_WRITE = 4;
  localparam int ST_DONE  = 5;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CLEAR = 6'b000010,
    S_FEED  = 6'b000100,
    S_DRAIN = 6'b001000,
    S_WRITE = 6'b010000,
    S_DONE  = 6'b100000
  } state_e;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control/strobe bundle between the register block,
// the PE array and the sequencer.
`timescale 1ns/1ps
interface matmul_sequencer_if;
  import matmul_pkg::*;

  logic                      start;
  logic [TGT_W-1:0]          sp_target;
  logic                      abort;
  logic                      ovf;
  logic                      busy;
  logic                      done;
  logic                      start_err;
  logic                      pe_clear;
  logic                      op_rd;
  logic [IDX_W-1:0]          rd_idx;
  logic                      pe_valid;
  logic [IDX_W-1:0]          res_row;
  logic                      sp_we;
  logic [LOC_ADDR_WIDTH-1:0] sp_addr;
  logic                      flags_we;
  logic                      ovf_flag;

  modport master (
    output start, sp_target, abort, ovf,
    input  busy, done, start_err, pe_clear,
    input  op_rd, rd_idx, pe_valid, res_row,
    input  sp_we, sp_addr, flags_we, ovf_flag
  );

  modport slave (
    input  start, sp_target, abort, ovf,
    output busy, done, start_err, pe_clear,
    output op_rd, rd_idx, pe_valid, res_row,
    output sp_we, sp_addr, flags_we, ovf_flag
  );

endinterface

// File: rtl/matmul_step_cnt.sv
// Loadable down-counter with terminal flag, used to
// time the FEED, DRAIN and WRITE phases.
`timescale 1ns/1ps
module matmul_step_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// Matmul phase sequencer: clear, operand feed, PE drain,
// result write-back and flag update, with abort/reset.
`timescale 1ns/1ps
module matmul_sequencer #(
  parameter int unsigned DATA_WIDTH     = matmul_pkg::DATA_WIDTH,
  parameter int unsigned BUS_WIDTH      = matmul_pkg::BUS_WIDTH,
  parameter int unsigned DIM            = BUS_WIDTH / DATA_WIDTH,
  parameter int unsigned SP_NTARGETS    = matmul_pkg::SP_NTARGETS,
  parameter int unsigned LOC_ADDR_WIDTH = matmul_pkg::LOC_ADDR_WIDTH,
  parameter int unsigned SP_BASE        = matmul_pkg::SP_BASE,
  parameter int unsigned PE_LAT         = 2 * DIM - 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic [matmul_pkg::clog2_min1(SP_NTARGETS)-1:0] sp_target_i,
  input  logic abort_i,
  input  logic ovf_i,
  output logic busy_o,
  output logic done_o,
  output logic start_err_o,
  output logic pe_clear_o,
  output logic op_rd_o,
  output logic [matmul_pkg::clog2_min1(DIM)-1:0] rd_idx_o,
  output logic pe_valid_o,
  output logic [matmul_pkg::clog2_min1(DIM)-1:0] res_row_o,
  output logic sp_we_o,
  output logic [LOC_ADDR_WIDTH-1:0] sp_addr_o,
  output logic flags_we_o,
  output logic ovf_o
);
  import matmul_pkg::*;

  localparam int unsigned TW   = clog2_min1(SP_NTARGETS);
  localparam int unsigned IW   = clog2_min1(DIM);
  localparam int unsigned AW   = LOC_ADDR_WIDTH;
  localparam int unsigned CMAX = (PE_LAT > DIM) ? PE_LAT : DIM;
  localparam int unsigned CW   = clog2_min1(CMAX);

  state_e        state_q, state_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;

  logic          ld;
  logic [CW-1:0] ld_val;
  logic          en;
  logic [CW-1:0] cnt;
  logic          tc;
  logic [IW-1:0] idx;
  logic [AW-1:0] addr;

  matmul_step_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (ld),
    .val_i  (ld_val),
    .en_i   (en),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ovf_d   = ovf_q;
    err_d   = start_i & ~state_q[ST_IDLE];
    vld_d   = state_q[ST_FEED];
    ld      = 1'b0;
    ld_val  = '0;
    en      = 1'b0;
    // abort only wins once the sequence is running
    if (abort_i && !state_q[ST_IDLE]) begin
      state_d = S_IDLE;
      ld      = 1'b1;
    end else begin
      unique case (1'b1)
        state_q[ST_IDLE]: begin
          if (start_i) begin
            state_d = S_CLEAR;
            tgt_d   = sp_target_i;
            ovf_d   = 1'b0;
          end
        end
        state_q[ST_CLEAR]: begin
          state_d = S_FEED;
          ld      = 1'b1;
          ld_val  = CW'(DIM - 1);
        end
        state_q[ST_FEED]: begin
          ovf_d = ovf_q | ovf_i;
          if (tc) begin
            state_d = S_DRAIN;
            ld      = 1'b1;
            ld_val  = CW'(PE_LAT - 1);
          end else begin
            en = 1'b1;
          end
        end
        state_q[ST_DRAIN]: begin
          ovf_d = ovf_q | ovf_i;
          if (tc) begin
            state_d = S_WRITE;
            ld      = 1'b1;
            ld_val  = CW'(DIM - 1);
          end else begin
            en = 1'b1;
          end
        end
        state_q[ST_WRITE]: begin
          if (tc) begin
            state_d = S_DONE;
          end else begin
            en = 1'b1;
          end
        end
        state_q[ST_DONE]: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // counter runs DIM-1..0, so the ascending index is its complement
  assign idx  = IW'(CW'(DIM - 1) - cnt);
  assign addr = AW'(SP_BASE) + AW'(tgt_q) * AW'(DIM) + AW'(idx);

  assign busy_o      = ~state_q[ST_IDLE];
  assign pe_clear_o  = state_q[ST_CLEAR];
  assign op_rd_o     = state_q[ST_FEED];
  assign sp_we_o     = state_q[ST_WRITE];
  assign done_o      = state_q[ST_DONE];
  assign flags_we_o  = state_q[ST_DONE];
  assign ovf_o       = state_q[ST_DONE] & ovf_q;
  assign start_err_o = err_q;
  assign pe_valid_o  = vld_q;
  assign rd_idx_o    = state_q[ST_FEED] ? idx : '0;
  assign res_row_o   = state_q[ST_WRITE] ? idx : '0;
  assign sp_addr_o   = state_q[ST_WRITE] ? addr : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: nominal run,
// overflow, start-while-busy, abort, async reset, back-to-back.
`timescale 1ns/1ps
module tb_matmul_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [17:0] trc    [0:20];
  logic        ovf_tr [0:20];

  matmul_sequencer_if bus ();

  matmul_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (bus.start),
    .sp_target_i (bus.sp_target),
    .abort_i     (bus.abort),
    .ovf_i       (bus.ovf),
    .busy_o      (bus.busy),
    .done_o      (bus.done),
    .start_err_o (bus.start_err),
    .pe_clear_o  (bus.pe_clear),
    .op_rd_o     (bus.op_rd),
    .rd_idx_o    (bus.rd_idx),
    .pe_valid_o  (bus.pe_valid),
    .res_row_o   (bus.res_row),
    .sp_we_o     (bus.sp_we),
    .sp_addr_o   (bus.sp_addr),
    .flags_we_o  (bus.flags_we),
    .ovf_o       (bus.ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] cap();
    return {bus.busy, bus.pe_clear, bus.op_rd, bus.rd_idx,
            bus.pe_valid, bus.sp_we, bus.res_row, bus.sp_addr,
            bus.done, bus.flags_we, bus.start_err};
  endfunction

  // cycle 1 = CLEAR, 2..5 FEED, 6..12 DRAIN, 13..16 WRITE, 17 DONE
  function automatic logic [17:0] model(
    input int c, input logic [1:0] t, input int ab, input int ec
  );
    logic busy, clr, rd, vld, we, dn, er;
    logic [1:0] idx, row;
    logic [5:0] ad;
    busy = (c >= 1 && c <= 17);
    clr  = (c == 1);
    rd   = (c >= 2 && c <= 5);
    idx  = rd ? 2'(c - 2) : 2'd0;
    vld  = (c >= 3 && c <= 6);
    we   = (c >= 13 && c <= 16);
    row  = we ? 2'(c - 13) : 2'd0;
    ad   = we ? 6'(16 + 4 * int'(t) + (c - 13)) : 6'd0;
    dn   = (c == 17);
    er   = (ec > 0 && c == ec + 1);
    if (ab > 0 && c > ab) begin
      busy = 0; clr = 0; rd = 0; idx = 0; vld = 0;
      we = 0; row = 0; ad = 0; dn = 0;
    end
    return {busy, clr, rd, idx, vld, we, row, ad, dn, dn, er};
  endfunction

  task automatic run_seq(
    input logic [1:0] tgt, input int ovf_c, input int st_c,
    input int ab_c, input int ncyc, input logic ab0
  );
    @(negedge clk);
    trc[0]    = cap();
    ovf_tr[0] = bus.ovf_flag;
    bus.start     = 1'b1;
    bus.sp_target = tgt;
    bus.abort     = ab0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      trc[c]    = cap();
      ovf_tr[c] = bus.ovf_flag;
      bus.start = (c == st_c);
      if (c == st_c) bus.sp_target = ~tgt;
      bus.abort = (c == ab_c);
      bus.ovf   = (c == ovf_c);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ovf   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (cap() !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", cap(), 18'h0);
    end
    n_tests++;
    if (bus.ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf got=%b exp=0", bus.ovf_flag);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_seq(2'd2, 0, 0, 0, 20, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd2, 0, 0)) begin
        n_fail++;
        $display("FAIL nominal c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd2, 0, 0));
      end
    end
    n_tests++;
    if (ovf_tr[17] !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_ovf got=%b exp=0", ovf_tr[17]);
    end
  endtask

  task automatic test_overflow();
    run_seq(2'd2, 9, 0, 0, 20, 1'b0);
    n_tests++;
    if (ovf_tr[17] !== 1'b1 || trc[17] !== model(17, 2'd2, 0, 0)) begin
      n_fail++;
      $display("FAIL ovf_set got=%b/%h exp=1/%h",
               ovf_tr[17], trc[17], model(17, 2'd2, 0, 0));
    end
    run_seq(2'd0, 0, 0, 0, 20, 1'b0);
    n_tests++;
    if (ovf_tr[17] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared got=%b exp=0", ovf_tr[17]);
    end
    for (int c = 13; c <= 17; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd0, 0, 0)) begin
        n_fail++;
        $display("FAIL ovf_rerun c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd0, 0, 0));
      end
    end
  endtask

  task automatic test_start_busy();
    run_seq(2'd2, 0, 3, 0, 20, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd2, 0, 3)) begin
        n_fail++;
        $display("FAIL start_busy c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd2, 0, 3));
      end
    end
  endtask

  task automatic test_abort();
    run_seq(2'd2, 0, 0, 8, 20, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd2, 8, 0)) begin
        n_fail++;
        $display("FAIL abort c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd2, 8, 0));
      end
    end
    run_seq(2'd1, 0, 0, 0, 20, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd1, 0, 0)) begin
        n_fail++;
        $display("FAIL abort_rerun c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd1, 0, 0));
      end
    end
  endtask

  task automatic test_start_abort_idle();
    run_seq(2'd0, 0, 0, 0, 20, 1'b1);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd0, 0, 0)) begin
        n_fail++;
        $display("FAIL start_abort_idle c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd0, 0, 0));
      end
    end
  endtask

  task automatic test_async_reset();
    run_seq(2'd1, 0, 0, 0, 13, 1'b0);
    for (int c = 0; c <= 13; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd1, 0, 0)) begin
        n_fail++;
        $display("FAIL arst_pre c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd1, 0, 0));
      end
    end
    @(negedge clk);
    n_tests++;
    if (cap() !== model(14, 2'd1, 0, 0)) begin
      n_fail++;
      $display("FAIL arst_row1 got=%h exp=%h",
               cap(), model(14, 2'd1, 0, 0));
    end
    #1 rst_n = 1'b0;
    #0.5;
    n_tests++;
    if (cap() !== 18'h0 || bus.ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate got=%h exp=%h", cap(), 18'h0);
    end
    #0.5 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (cap() !== 18'h0) begin
        n_fail++;
        $display("FAIL arst_after c=%0d got=%h exp=%h",
                 c, cap(), 18'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_seq(2'd2, 0, 0, 0, 17, 1'b0);
    for (int c = 0; c <= 17; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd2, 0, 0)) begin
        n_fail++;
        $display("FAIL b2b_first c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd2, 0, 0));
      end
    end
    run_seq(2'd3, 0, 0, 0, 20, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      n_tests++;
      if (trc[c] !== model(c, 2'd3, 0, 0)) begin
        n_fail++;
        $display("FAIL b2b_second c=%0d got=%h exp=%h",
                 c, trc[c], model(c, 2'd3, 0, 0));
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.sp_target = 2'd0;
    bus.abort     = 1'b0;
    bus.ovf       = 1'b0;
    test_reset();
    test_nominal();
    test_overflow();
    test_start_busy();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
